// File: rtl/fir_out_stage_if.sv
// Stream bundle for the FIR output stage.
// The accumulator input side and the rounded-sample output side share one interface.
interface fir_out_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic [2*WIDTH-1:0]   in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;

  // Upstream tap chain and downstream consumer drive this side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The output stage itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_out_stage.sv
// FIR output conditioning: round, arithmetic shift and saturate the 2*WIDTH accumulator.
// Two-stage valid/ready pipeline with sticky saturation statistics.
module fir_out_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  fir_out_stage_if.slave    bus,
  input  logic              clr_stat,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  sat_count
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned EXT_W = ACC_W + 1;

  // Half-LSB rounding constant; collapses to zero when SHIFT is zero.
  localparam logic signed [EXT_W-1:0] RND     = (EXT_W'(1) << SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [WIDTH-1:0]        OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    s1_valid_q, s1_valid_d;
  logic signed [EXT_W-1:0] s1_q, s1_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

  logic                    s1_load_c;
  logic                    s2_load_c;
  logic                    in_ready_c;
  logic                    sat_hi_c;
  logic                    sat_lo_c;
  logic                    sat_evt_c;
  logic signed [EXT_W-1:0] sum_c;

  // Handshake: S2 refills when empty or draining; S1 refills when empty or moving to S2.
  always_comb begin
    s2_load_c  = s1_valid_q && (!out_valid_q || bus.out_ready);
    in_ready_c = !s1_valid_q || s2_load_c;
    s1_load_c  = bus.in_valid && in_ready_c;
  end

  // Rounding add on the sign-extended accumulator cannot overflow.
  always_comb begin
    sum_c     = $signed({bus.in_data[ACC_W-1], bus.in_data}) + RND;
    sat_hi_c  = s1_q > SAT_MAX;
    sat_lo_c  = s1_q < SAT_MIN;
    sat_evt_c = s2_load_c && (sat_hi_c || sat_lo_c);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_load_c) begin
      s1_valid_d = 1'b1;
      s1_d       = sum_c >>> SHIFT;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // Output register holds while stalled; clears valid only on a transfer with nothing behind it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s2_load_c) begin
      out_valid_d = 1'b1;
      if (sat_hi_c) begin
        out_data_d = OUT_MAX;
      end else if (sat_lo_c) begin
        out_data_d = OUT_MIN;
      end else begin
        out_data_d = s1_q[WIDTH-1:0];
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A saturation event beats a simultaneous clear.
  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (sat_evt_c) begin
      sat_flag_d = 1'b1;
      if (clr_stat) begin
        sat_cnt_d = CNT_W'(1);
      end else if (!(&sat_cnt_q)) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
    end else if (clr_stat) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign sat_flag      = sat_flag_q;
  assign sat_count     = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: rounding, saturation, backpressure, stats clear and reset.
module tb_fir_out_stage;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 16;

  logic              clk;
  logic              rst;
  logic              clr_stat;
  logic              sat_flag;
  logic [CNT_W-1:0]  sat_count;

  int n_cmp;
  int n_bad;
  logic [WIDTH-1:0] got_q[$];

  fir_out_stage_if #(.WIDTH(WIDTH)) bus ();

  fir_out_stage #(.WIDTH(WIDTH), .SHIFT(15), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_stat  (clr_stat),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_one(input string tag, input logic [31:0] d, input logic [15:0] exp_d);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_data), 64'(exp_d));
  endtask

  initial begin
    int          k;
    int          stall;
    logic        seen;
    logic        saw_block;
    logic        accepted;

    n_cmp = 0;
    n_bad = 0;
    rst           = 1'b1;
    clr_stat      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_sat_flag",  64'(sat_flag),      64'd0);
    check("rst_sat_count", 64'(sat_count),     64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Rounding and negative half-tie behaviour.
    send_one("round_up", 32'h0000_4000, 16'h0001);
    check("round_up_flag", 64'(sat_flag), 64'd0);
    send_one("neg_tie", 32'hFFFF_C000, 16'h0000);
    send_one("neg_below", 32'hFFFF_BFFF, 16'hFFFF);
    check("neg_flag", 64'(sat_flag), 64'd0);

    // Saturation at both rails, and the exact minimum that is not clipped.
    send_one("sat_pos", 32'h4000_0000, 16'h7FFF);
    check("sat_pos_flag",  64'(sat_flag),  64'd1);
    check("sat_pos_count", 64'(sat_count), 64'd1);
    send_one("sat_neg", 32'hBFFF_0000, 16'h8000);
    check("sat_neg_count", 64'(sat_count), 64'd2);
    send_one("exact_min", 32'hC000_0000, 16'h8000);
    check("exact_min_count", 64'(sat_count), 64'd2);

    // Backpressure: stream 1..6 and stall the consumer for 4 cycles.
    @(posedge clk); #1;
    got_q.delete();
    k = 1;
    stall = 0;
    seen = 1'b0;
    saw_block = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'(k) << 15;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got_q.size() < 6; cyc++) begin
      @(negedge clk);
      if (!bus.in_ready) saw_block = 1'b1;
      if (bus.out_valid && !bus.out_ready) check("bp_hold", 64'(bus.out_data), 64'h0001);
      accepted = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (accepted) begin
        if (k == 6) begin
          bus.in_valid = 1'b0;
        end else begin
          k++;
          bus.in_data = 32'(k) << 15;
        end
      end
      if (bus.out_valid && !seen) begin
        seen  = 1'b1;
        stall = 4;
      end
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_in_ready_drop", 64'(saw_block), 64'd1);
    check("bp_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      check($sformatf("bp_out%0d", i), 64'(got_q[i]), 64'(i + 1));
    end

    // Clear racing a saturation event: the event wins.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4000_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    clr_stat     = 1'b1;
    @(posedge clk); #1;
    check("race_data",  64'(bus.out_data), 64'h7FFF);
    check("race_flag",  64'(sat_flag),     64'd1);
    check("race_count", 64'(sat_count),    64'd1);
    @(posedge clk); #1;
    clr_stat = 1'b0;
    check("clr_flag",  64'(sat_flag),  64'd0);
    check("clr_count", 64'(sat_count), 64'd0);

    // Reset with both stages full and the consumer stalled.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_8000;
    @(posedge clk); #1;
    bus.in_data = 32'h0001_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("full_in_ready",  64'(bus.in_ready),  64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_out_data",  64'(bus.out_data),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("no_stale%0d", i), 64'(bus.out_valid), 64'd0);
    end
    send_one("post_rst", 32'h0001_8000, 16'h0003);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
